spike_window_packer: RTL and testbench

- Producer side of the temporal-pattern interface: collects one spike bit per timestep from a LIF neuron or input stream.
- Packs T_WINDOW consecutive timesteps into a T_WINDOW-bit pattern and presents it downstream via valid/ready; the downstream consumer is the pattern matcher input.
- Bit t of the pattern is the spike at timestep t of the window (first timestep = bit 0), matching weight-pattern bit ordering.
- One complete window can be parked internally while the output register is occupied.

---
 rtl/spike_window_packer.sv | 155 +++++++++++++++
 tb/tb_spike_window_packer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/spike_window_packer.sv
// Packs T_WINDOW single-bit spike beats into one pattern word with a valid/ready output and a
// one-window park slot. Optional running spike count on the output under SPIKE_PACKER_COUNT_EN.
module spike_window_packer #(
   parameter int unsigned T_WINDOW  = 16,
   parameter int unsigned CNT_W     = $clog2(T_WINDOW),
   parameter int unsigned SCORE_W   = $clog2(T_WINDOW + 1),
   parameter int unsigned WIN_CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 in_valid,
   input  logic                 in_spike,
   output logic                 in_ready,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [T_WINDOW-1:0]  out_pattern,
   output logic [WIN_CNT_W-1:0] win_count
`ifdef SPIKE_PACKER_COUNT_EN
   ,
   output logic [SCORE_W-1:0]   out_count
`endif
);

   typedef enum logic {
      StFill = 1'b0,
      StHold = 1'b1
   } state_e;

   localparam logic [CNT_W-1:0] LastIdx = CNT_W'(T_WINDOW - 1);

   state_e                 state_q, state_d;
   logic [T_WINDOW-1:0]    acc_q, acc_d;
   logic [CNT_W-1:0]       idx_q, idx_d;
   logic                   out_valid_q, out_valid_d;
   logic [T_WINDOW-1:0]    out_pattern_q, out_pattern_d;
   logic [WIN_CNT_W-1:0]   win_count_q, win_count_d;

   logic                   accept;
   logic                   last_beat;
   logic                   slot_free;
   logic                   xfer;
   logic                   load_live;
   logic                   park;
   logic                   load_park;
   logic [T_WINDOW-1:0]    full;

   assign in_ready    = (state_q == StFill) && !flush && !rst;
   assign accept      = in_valid && in_ready;
   assign last_beat   = accept && (idx_q == LastIdx);
   assign slot_free   = !out_valid_q || out_ready;
   assign xfer        = out_valid_q && out_ready;
   assign load_live   = last_beat && slot_free;
   assign park        = last_beat && !slot_free;
   assign load_park   = (state_q == StHold) && slot_free && !flush;

   assign out_valid   = out_valid_q;
   assign out_pattern = out_pattern_q;
   assign win_count   = win_count_q;

   always_comb begin
      full                = acc_q;
      full[T_WINDOW-1]    = in_spike;
   end

   always_comb begin
      state_d       = state_q;
      acc_d         = acc_q;
      idx_d         = idx_q;
      out_valid_d   = out_valid_q && !out_ready;
      out_pattern_d = out_pattern_q;
      win_count_d   = win_count_q + WIN_CNT_W'(xfer);

      if (flush) begin
         // Discards the partial or parked window; the output register is left alone.
         acc_d   = '0;
         idx_d   = '0;
         state_d = StFill;
      end else if (load_live) begin
         acc_d = '0;
         idx_d = '0;
      end else if (park) begin
         acc_d   = full;
         idx_d   = '0;
         state_d = StHold;
      end else if (accept) begin
         acc_d[idx_q] = in_spike;
         idx_d        = idx_q + CNT_W'(1);
      end else if (load_park) begin
         acc_d   = '0;
         state_d = StFill;
      end

      if (load_live) begin
         out_valid_d   = 1'b1;
         out_pattern_d = full;
      end else if (load_park) begin
         out_valid_d   = 1'b1;
         out_pattern_d = acc_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= StFill;
         acc_q         <= '0;
         idx_q         <= '0;
         out_valid_q   <= 1'b0;
         out_pattern_q <= '0;
         win_count_q   <= '0;
      end else begin
         state_q       <= state_d;
         acc_q         <= acc_d;
         idx_q         <= idx_d;
         out_valid_q   <= out_valid_d;
         out_pattern_q <= out_pattern_d;
         win_count_q   <= win_count_d;
      end
   end

`ifdef SPIKE_PACKER_COUNT_EN
   logic [SCORE_W-1:0] cnt_acc_q, cnt_acc_d;
   logic [SCORE_W-1:0] out_count_q, out_count_d;

   // Running count tracks acc so the output count never needs a popcount of the pattern.
   always_comb begin
      cnt_acc_d   = cnt_acc_q;
      out_count_d = out_count_q;
      if (flush) begin
         cnt_acc_d = '0;
      end else if (load_live) begin
         out_count_d = cnt_acc_q + SCORE_W'(in_spike);
         cnt_acc_d   = '0;
      end else if (accept) begin
         cnt_acc_d = cnt_acc_q + SCORE_W'(in_spike);
      end else if (load_park) begin
         out_count_d = cnt_acc_q;
         cnt_acc_d   = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_acc_q   <= '0;
         out_count_q <= '0;
      end else begin
         cnt_acc_q   <= cnt_acc_d;
         out_count_q <= out_count_d;
      end
   end

   assign out_count = out_count_q;
`endif

endmodule

// File: tb/tb_spike_window_packer.sv
// Directed self-checking bench for spike_window_packer (T_WINDOW=16).
module tb_spike_window_packer;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_spike;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_pattern;
   logic [15:0] win_count;
`ifdef SPIKE_PACKER_COUNT_EN
   logic [4:0]  out_count;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   spike_window_packer dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_spike    (in_spike),
      .in_ready    (in_ready),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_pattern (out_pattern),
      .win_count   (win_count)
`ifdef SPIKE_PACKER_COUNT_EN
      ,
      .out_count   (out_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_window(input logic [15:0] pat);
      for (int t = 0; t < 16; t++) begin
         in_valid = 1'b1;
         in_spike = pat[t];
         tick();
      end
      in_valid = 1'b0;
      in_spike = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      logic [31:0] stream;
      logic [15:0] pulses [2];
      int          pulse_at [2];
      int          np;
      int          drops;

      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_spike  = 1'b0;
      out_ready = 1'b0;

      // Reset state
      tick();
      tick();
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_pattern", out_pattern, 0);
      check("rst_win_count", win_count, 0);
      rst = 1'b0;
      tick();
      check("post_rst_in_ready", in_ready, 1);

      // Basic pack: 1,0,1,1 then zeros -> 0x000D
      out_ready = 1'b1;
      for (int t = 0; t < 16; t++) begin
         in_valid = 1'b1;
         in_spike = (t == 0 || t == 2 || t == 3);
         if (t == 15) check("basic_pre_valid", out_valid, 0);
         tick();
      end
      in_valid = 1'b0;
      in_spike = 1'b0;
      check("basic_valid", out_valid, 1);
      check("basic_pattern", out_pattern, 32'h000D);
`ifdef SPIKE_PACKER_COUNT_EN
      check("basic_count", out_count, 3);
`endif
      tick();
      check("basic_drained", out_valid, 0);
      check("basic_win_count", win_count, 1);

      // Back-to-back: 0xFFFF then 0xAAAA with no bubbles
      stream = 32'hAAAA_FFFF;
      np     = 0;
      drops  = 0;
      for (int i = 0; i < 32; i++) begin
         in_valid = 1'b1;
         in_spike = stream[i];
         if (!in_ready) drops++;
         tick();
         if (out_valid) begin
            if (np < 2) begin
               pulses[np]   = out_pattern;
               pulse_at[np] = i;
            end
            np++;
         end
      end
      in_valid = 1'b0;
      in_spike = 1'b0;
      tick();
      check("b2b_ready_drops", drops, 0);
      check("b2b_pulses", np, 2);
      check("b2b_first", pulses[0], 32'hFFFF);
      check("b2b_second", pulses[1], 32'hAAAA);
      check("b2b_spacing", pulse_at[1] - pulse_at[0], 16);
      check("b2b_win_count", win_count, 3);
      check("b2b_idle", out_valid, 0);

      // Backpressure: second window parks in HOLD
      out_ready = 1'b0;
      send_window(16'h00FF);
      check("bp_first_valid", out_valid, 1);
      send_window(16'hF000);
      check("bp_hold_ready", in_ready, 0);
      check("bp_hold_pattern", out_pattern, 32'h00FF);
      tick();
      tick();
      check("bp_stable_pattern", out_pattern, 32'h00FF);
      check("bp_stable_valid", out_valid, 1);
`ifdef SPIKE_PACKER_COUNT_EN
      check("bp_count_first", out_count, 8);
`endif
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("bp_parked_pattern", out_pattern, 32'hF000);
      check("bp_parked_valid", out_valid, 1);
      check("bp_ready_back", in_ready, 1);
      check("bp_win_count", win_count, 4);
`ifdef SPIKE_PACKER_COUNT_EN
      check("bp_count_parked", out_count, 4);
`endif
      out_ready = 1'b1;
      tick();
      check("bp_drained", out_valid, 0);
      check("bp_win_count2", win_count, 5);

      // Flush discards a partial window
      do_reset();
      out_ready = 1'b1;
      for (int t = 0; t < 5; t++) begin
         in_valid = 1'b1;
         in_spike = 1'b1;
         tick();
      end
      flush = 1'b1;
      #1;
      check("flush_in_ready", in_ready, 0);
      tick();
      flush = 1'b0;
      send_window(16'h0001);
      check("flush_valid", out_valid, 1);
      check("flush_pattern", out_pattern, 32'h0001);
`ifdef SPIKE_PACKER_COUNT_EN
      check("flush_count", out_count, 1);
`endif
      tick();
      check("flush_win_count", win_count, 1);

      // Async reset while a window is parked
      do_reset();
      out_ready = 1'b0;
      send_window(16'h00FF);
      send_window(16'hF000);
      check("ar_hold_ready", in_ready, 0);
      #2;
      rst = 1'b1;
      #1;
      check("ar_valid_async", out_valid, 0);
      check("ar_ready_async", in_ready, 0);
      check("ar_pattern_async", out_pattern, 0);
      tick();
      rst       = 1'b0;
      out_ready = 1'b1;
      tick();
      tick();
      tick();
      check("ar_no_emit", out_valid, 0);
      check("ar_win_count", win_count, 0);
      check("ar_ready", in_ready, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
